// File: rtl/alu_array_pipe.sv
// -----------------------------------------------------------------------------
// alu_array_pipe
//
// Array of CHANNELS independent unsigned ALU channels behind a two-stage
// valid/ready pipeline. Stage 1 captures operands, opcodes and the accumulator
// clear bit; stage 2 computes and holds result and flags. Every channel owns a
// (WIDTH+1)-bit accumulator with a sticky overflow bit.
//
// Ports
//   wb_clk_i   : clock, rising edge
//   wb_rst_i   : asynchronous active-high reset
//   in_valid   : input transaction presented
//   in_ready   : input transaction accepted this cycle
//   a_i, b_i   : operands, channel k at [k*WIDTH +: WIDTH]
//   op_i       : opcodes, channel k at [k*3 +: 3]
//   acc_clr_i  : clear all accumulators with this transaction
//   out_valid  : result_o / flags_o hold a valid result
//   out_ready  : downstream takes the result
//   result_o   : results, channel k at [k*(WIDTH+1) +: WIDTH+1]
//   flags_o    : flags, channel k at [k*2 +: 2] = {ovf, zero}
// -----------------------------------------------------------------------------
module alu_array_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     a_i,
  input  logic [CHANNELS*WIDTH-1:0]     b_i,
  input  logic [CHANNELS*3-1:0]         op_i,
  input  logic                          acc_clr_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*(WIDTH+1)-1:0] result_o,
  output logic [CHANNELS*2-1:0]         flags_o
);

  localparam int RW = WIDTH + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_ACC  = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Returns {raw_ovf, result}. For ACC the raw ovf is the wrap of this
  // addition only; the sticky part is merged by the caller.
  function automatic logic [RW:0] alu_fn(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [RW-1:0]    acc_base
  );
    logic [RW-1:0] res;
    logic          ovf;
    logic [RW:0]   acc_sum;
    res     = '0;
    ovf     = 1'b0;
    acc_sum = {1'b0, acc_base} + {2'b00, a};
    case (op)
      OP_ADD: begin
        res = {1'b0, a} + {1'b0, b};
        ovf = res[WIDTH];
      end
      OP_SUB: begin
        res = {1'b0, a} - {1'b0, b};
        ovf = (a < b);
      end
      OP_AND: res = {1'b0, a & b};
      OP_OR:  res = {1'b0, a | b};
      OP_XOR: res = {1'b0, a ^ b};
      OP_ACC: begin
        res = acc_sum[RW-1:0];
        ovf = acc_sum[RW];
      end
      OP_CMP: begin
        res[1] = (a == b);
        res[0] = (a < b);
      end
      default: res = {1'b0, a};
    endcase
    return {ovf, res};
  endfunction

  logic                      r_vld_p1;
  logic                      r_vld_p2;
  logic [CHANNELS*WIDTH-1:0] r_a_p1;
  logic [CHANNELS*WIDTH-1:0] r_b_p1;
  logic [CHANNELS*3-1:0]     r_op_p1;
  logic                      r_clr_p1;
  logic                      w_adv2;
  logic                      w_accept;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign w_adv2    = r_vld_p1 & (~r_vld_p2 | out_ready);
  assign in_ready  = ~r_vld_p1 | w_adv2;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_vld_p2;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_accept)    r_vld_p1 <= 1'b1;
      else if (w_adv2) r_vld_p1 <= 1'b0;
      if (w_adv2)         r_vld_p2 <= 1'b1;
      else if (out_ready) r_vld_p2 <= 1'b0;
    end
  end

  // ---- stage 1: capture operands, opcodes and clear bit ----
  always_ff @(posedge wb_clk_i) begin
    if (w_accept) begin
      r_a_p1   <= a_i;
      r_b_p1   <= b_i;
      r_op_p1  <= op_i;
      r_clr_p1 <= acc_clr_i;
    end
  end

  // ---- stage 2: compute per channel, update accumulators, hold outputs ----
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [RW-1:0]    r_acc;
    logic             r_ovf;
    logic [RW-1:0]    r_res_p2;
    logic [1:0]       r_flg_p2;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [RW-1:0]    w_acc_base;
    logic             w_ovf_base;
    logic [RW-1:0]    w_res;
    logic             w_ovf_raw;
    logic             w_ovf_flag;

    assign w_op = r_op_p1[g*3 +: 3];
    assign w_a  = r_a_p1[g*WIDTH +: WIDTH];
    assign w_b  = r_b_p1[g*WIDTH +: WIDTH];

    // Clear takes effect before this transaction's own op.
    assign w_acc_base = r_clr_p1 ? '0 : r_acc;
    assign w_ovf_base = r_clr_p1 ? 1'b0 : r_ovf;

    assign {w_ovf_raw, w_res} = alu_fn(w_op, w_a, w_b, w_acc_base);
    assign w_ovf_flag = (w_op == OP_ACC) ? (w_ovf_base | w_ovf_raw) : w_ovf_raw;

    // Accumulator state moves only on the stage 1 -> 2 transfer, so stalls
    // can never apply an ACC twice.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        r_acc    <= '0;
        r_ovf    <= 1'b0;
        r_res_p2 <= '0;
        r_flg_p2 <= 2'b00;
      end else if (w_adv2) begin
        r_res_p2 <= w_res;
        r_flg_p2 <= {w_ovf_flag, (w_res[WIDTH-1:0] == '0)};
        if (w_op == OP_ACC) begin
          r_acc <= w_res;
          r_ovf <= w_ovf_flag;
        end else if (r_clr_p1) begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end
      end
    end

    assign result_o[g*RW +: RW] = r_res_p2;
    assign flags_o[g*2 +: 2]    = r_flg_p2;
  end

endmodule
